ddr_cmd_scheduler: RTL and testbench

Command scheduler between the wishbone SDRAM slave and the DDR controller core. It shares the controller's single command port between user read/write requests and an internal auto-refresh timer. Refreshes are postponed while user traffic is present, up to a fixed credit limit, after which a refresh is forced. Only after `ddr_ready` does it issue any command.

---
 rtl/ddr_cmd_scheduler_if.sv | 22 ++
 rtl/ddr_cmd_scheduler.sv | 131 +++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_scheduler_if.sv
// User request and controller command port bundle for ddr_cmd_scheduler.
// master = scheduler side, slave = user/controller side.
interface ddr_cmd_scheduler_if;
   logic        req_vld;
   logic        req_write;
   logic [31:0] req_addr;
   logic        req_ack;
   logic [4:0]  cmd;
   logic        cmd_vld;
   logic [31:0] addr;
   logic        busy;

   modport master (
      input  req_vld, req_write, req_addr, busy,
      output req_ack, cmd, cmd_vld, addr
   );

   modport slave (
      output req_vld, req_write, req_addr, busy,
      input  req_ack, cmd, cmd_vld, addr
   );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// Shares the DDR controller command port between user requests and auto-refresh.
// Optional refresh statistics counters: define DDR_SCHED_STATS_EN.
module ddr_cmd_scheduler #(
   parameter int REFI_CYCLES  = 390,
   parameter int MAX_POSTPONE = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ddr_ready,
   ddr_cmd_scheduler_if.master bus,
   output logic [3:0]          refresh_owed,
   output logic                refresh_err,
   output logic [15:0]         stat_refresh,
   output logic [15:0]         stat_urgent
);

   localparam int TW = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
   localparam logic [4:0] CMD_READ  = 5'h04;
   localparam logic [4:0] CMD_WRITE = 5'h05;
   localparam logic [4:0] CMD_AR    = 5'h08;

   typedef enum logic [1:0] {IDLE, ISSUE_USER, ISSUE_REF} state_t;

   state_t          state, nxt_state;
   logic [TW-1:0]   timer;
   logic            tick;
   logic            urgent;
   logic            ref_acc;
   logic [31:0]     addr_q;
   logic            write_q;
   logic            urgent_q;

   assign tick   = ddr_ready && (timer == TW'(REFI_CYCLES - 1));
   assign urgent = (refresh_owed >= 4'(MAX_POSTPONE));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE: begin
            if (ddr_ready) begin
               if (urgent)                  nxt_state = ISSUE_REF;
               else if (bus.req_vld)        nxt_state = ISSUE_USER;
               else if (refresh_owed != '0) nxt_state = ISSUE_REF;
            end
         end
         ISSUE_USER, ISSUE_REF: begin
            if (!ddr_ready || !bus.busy) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_vld = 1'b0;
      bus.cmd     = '0;
      bus.addr    = '0;
      bus.req_ack = 1'b0;
      ref_acc     = 1'b0;
      case (state)
         ISSUE_USER: begin
            bus.cmd_vld = 1'b1;
            bus.cmd     = write_q ? CMD_WRITE : CMD_READ;
            bus.addr    = addr_q;
            bus.req_ack = ddr_ready && !bus.busy;
         end
         ISSUE_REF: begin
            bus.cmd_vld = 1'b1;
            bus.cmd     = CMD_AR;
            ref_acc     = ddr_ready && !bus.busy;
         end
         default: ;
      endcase
   end

   // Request fields and the urgency of a chosen refresh are captured on entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         write_q  <= 1'b0;
         urgent_q <= 1'b0;
      end else if (state == IDLE) begin
         if (nxt_state == ISSUE_USER) begin
            addr_q  <= bus.req_addr;
            write_q <= bus.req_write;
         end
         if (nxt_state == ISSUE_REF) urgent_q <= urgent;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !ddr_ready) timer <= '0;
      else if (tick)         timer <= '0;
      else                   timer <= timer + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || !ddr_ready) begin
         refresh_owed <= '0;
      end else if (tick && !ref_acc) begin
         if (!urgent) refresh_owed <= refresh_owed + 1'b1;
      end else if (!tick && ref_acc) begin
         refresh_owed <= refresh_owed - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                        refresh_err <= 1'b0;
      else if (tick && (refresh_owed == 4'(MAX_POSTPONE))) refresh_err <= 1'b1;
   end

`ifdef DDR_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_refresh <= '0;
         stat_urgent  <= '0;
      end else if (ref_acc) begin
         stat_refresh <= stat_refresh + 1'b1;
         if (urgent_q) stat_urgent <= stat_urgent + 1'b1;
      end
   end
`else
   assign stat_refresh = '0;
   assign stat_urgent  = '0;
`endif

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed self-checking bench for ddr_cmd_scheduler (REFI_CYCLES=390, MAX_POSTPONE=8).
module tb_ddr_cmd_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        ddr_ready;
   logic [3:0]  refresh_owed;
   logic        refresh_err;
   logic [15:0] stat_refresh;
   logic [15:0] stat_urgent;

   ddr_cmd_scheduler_if bus_if ();

   ddr_cmd_scheduler #(.REFI_CYCLES(390), .MAX_POSTPONE(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .ddr_ready    (ddr_ready),
      .bus          (bus_if),
      .refresh_owed (refresh_owed),
      .refresh_err  (refresh_err),
      .stat_refresh (stat_refresh),
      .stat_urgent  (stat_urgent)
   );

   always #5 clk = ~clk;

`ifdef DDR_SCHED_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   typedef struct {
      logic        ready;
      logic        req_vld;
      logic        req_write;
      logic [31:0] req_addr;
      logic        busy;
      logic        exp_vld;
      logic [4:0]  exp_cmd;
      logic [31:0] exp_addr;
      logic        exp_ack;
   } vec_t;

   vec_t vecs [12];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy, input logic rv, input logic wr,
                           input logic [31:0] ad, input logic bz);
      rst = 1'b1;
      ddr_ready = 1'b0;
      bus_if.req_vld = 1'b0;
      bus_if.busy = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      ddr_ready = rdy;
      bus_if.req_vld = rv;
      bus_if.req_write = wr;
      bus_if.req_addr = ad;
      bus_if.busy = bz;
   endtask

   initial begin
      int ar_edge, read_cnt, bad, ack_cnt;

      vecs[0]  = '{1, 1, 0, 32'h0000_1234, 0, 0, 5'h00, 32'h0, 0};
      vecs[1]  = '{1, 1, 0, 32'h0000_1234, 1, 1, 5'h04, 32'h0000_1234, 0};
      vecs[2]  = '{1, 1, 0, 32'h0000_1234, 0, 1, 5'h04, 32'h0000_1234, 1};
      vecs[3]  = '{1, 0, 0, 32'h0000_0000, 0, 0, 5'h00, 32'h0, 0};
      vecs[4]  = '{1, 1, 1, 32'hDEAD_BEE0, 1, 0, 5'h00, 32'h0, 0};
      vecs[5]  = '{1, 1, 1, 32'hFFFF_FFFF, 1, 1, 5'h05, 32'hDEAD_BEE0, 0};
      vecs[6]  = '{1, 1, 1, 32'hFFFF_FFFF, 0, 1, 5'h05, 32'hDEAD_BEE0, 1};
      vecs[7]  = '{0, 1, 0, 32'h0000_0010, 0, 0, 5'h00, 32'h0, 0};
      vecs[8]  = '{0, 1, 0, 32'h0000_0010, 0, 0, 5'h00, 32'h0, 0};
      vecs[9]  = '{1, 1, 0, 32'h0000_0010, 0, 0, 5'h00, 32'h0, 0};
      vecs[10] = '{0, 1, 0, 32'h0000_0010, 0, 1, 5'h04, 32'h0000_0010, 0};
      vecs[11] = '{0, 1, 0, 32'h0000_0010, 0, 0, 5'h00, 32'h0, 0};

      // Reset values, then 1000 cycles with ddr_ready low and a pending request
      rst = 1'b1;
      ddr_ready = 1'b0;
      bus_if.req_vld = 1'b1;
      bus_if.req_write = 1'b0;
      bus_if.req_addr = 32'h0000_1234;
      bus_if.busy = 1'b0;
      repeat (3) step();
      chk("rst_cmd_vld", 32'(bus_if.cmd_vld), 0);
      chk("rst_cmd", 32'(bus_if.cmd), 0);
      chk("rst_addr", bus_if.addr, 0);
      chk("rst_owed", 32'(refresh_owed), 0);
      chk("rst_err", 32'(refresh_err), 0);
      chk("rst_stat_refresh", 32'(stat_refresh), 0);
      chk("rst_stat_urgent", 32'(stat_urgent), 0);
      chk("rst_ack", 32'(bus_if.req_ack), 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (bus_if.cmd_vld || bus_if.req_ack || refresh_owed != 0) bad++;
      end
      chk("notready_quiet_cycles", 32'(bad), 0);

      // Table-driven single-cycle vectors
      for (int i = 0; i < 12; i++) begin
         ddr_ready = vecs[i].ready;
         bus_if.req_vld = vecs[i].req_vld;
         bus_if.req_write = vecs[i].req_write;
         bus_if.req_addr = vecs[i].req_addr;
         bus_if.busy = vecs[i].busy;
         @(negedge clk);
         chk($sformatf("vec%0d_cmd_vld", i), 32'(bus_if.cmd_vld), 32'(vecs[i].exp_vld));
         chk($sformatf("vec%0d_cmd", i), 32'(bus_if.cmd), 32'(vecs[i].exp_cmd));
         chk($sformatf("vec%0d_addr", i), bus_if.addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_ack", i), 32'(bus_if.req_ack), 32'(vecs[i].exp_ack));
         chk($sformatf("vec%0d_owed", i), 32'(refresh_owed), 0);
         step();
      end

      // First refresh after 390 ready cycles, idle user
      do_reset(1, 0, 0, 32'h0, 0);
      repeat (389) step();
      chk("ar_owed_before_tick", 32'(refresh_owed), 0);
      chk("ar_vld_before_tick", 32'(bus_if.cmd_vld), 0);
      step();
      chk("ar_owed_after_tick", 32'(refresh_owed), 1);
      chk("ar_vld_tick_cycle", 32'(bus_if.cmd_vld), 0);
      step();
      chk("ar_vld", 32'(bus_if.cmd_vld), 1);
      chk("ar_cmd", 32'(bus_if.cmd), 32'h08);
      chk("ar_addr", bus_if.addr, 0);
      chk("ar_owed_during", 32'(refresh_owed), 1);
      step();
      chk("ar_owed_after_accept", 32'(refresh_owed), 0);
      chk("ar_vld_after_accept", 32'(bus_if.cmd_vld), 0);
      chk("ar_stat_refresh", 32'(stat_refresh), 32'(STATS));
      chk("ar_stat_urgent", 32'(stat_urgent), 0);

      // Continuous reads until the urgent refresh is forced in
      do_reset(1, 1, 0, 32'h0000_1234, 0);
      ar_edge = 0;
      read_cnt = 0;
      bad = 0;
      for (int cyc = 1; cyc <= 4000; cyc++) begin
         step();
         if (bus_if.cmd_vld && bus_if.cmd == 5'h08) begin
            ar_edge = cyc;
            break;
         end
         if (bus_if.cmd_vld) begin
            if (bus_if.cmd == 5'h04 && bus_if.addr == 32'h0000_1234 && bus_if.req_ack
                && (cyc % 2) == 1)
               read_cnt++;
            else
               bad++;
         end else if ((cyc % 2) == 1) begin
            bad++;
         end
      end
      chk("urg_ar_edge", 32'(ar_edge), 3121);
      chk("urg_read_count", 32'(read_cnt), 1560);
      chk("urg_read_pattern_bad", 32'(bad), 0);
      chk("urg_owed_at_ar", 32'(refresh_owed), 8);
      chk("urg_ar_addr", bus_if.addr, 0);
      step();
      chk("urg_owed_after", 32'(refresh_owed), 7);
      chk("urg_vld_after", 32'(bus_if.cmd_vld), 0);
      chk("urg_stat_urgent", 32'(stat_urgent), 32'(STATS));
      chk("urg_stat_refresh", 32'(stat_refresh), 32'(STATS));
      bus_if.req_vld = 1'b0;

      // Write held by busy for 5 cycles
      do_reset(1, 1, 1, 32'hDEAD_BEE0, 1);
      step();
      ack_cnt = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (!(bus_if.cmd_vld && bus_if.cmd == 5'h05 && bus_if.addr == 32'hDEAD_BEE0)) bad++;
         if (bus_if.req_ack) ack_cnt++;
         if (i < 4) step();
      end
      chk("busy_stable_bad", 32'(bad), 0);
      bus_if.busy = 1'b0;
      #1;
      if (bus_if.req_ack) ack_cnt++;
      chk("busy_cmd_at_release", 32'(bus_if.cmd), 32'h05);
      step();
      bus_if.req_vld = 1'b0;
      #1;
      if (bus_if.req_ack) ack_cnt++;
      chk("busy_ack_count", 32'(ack_cnt), 1);
      chk("busy_vld_after", 32'(bus_if.cmd_vld), 0);

      // Busy through 9 ticks: saturation and sticky error, then ddr_ready drop
      do_reset(1, 0, 0, 32'h0, 1);
      repeat (3509) step();
      chk("sat_owed_8", 32'(refresh_owed), 8);
      chk("sat_err_before", 32'(refresh_err), 0);
      chk("sat_cmd_ar", 32'(bus_if.cmd), 32'h08);
      step();
      chk("sat_owed_saturated", 32'(refresh_owed), 8);
      chk("sat_err_set", 32'(refresh_err), 1);
      chk("sat_vld_held", 32'(bus_if.cmd_vld), 1);
      ddr_ready = 1'b0;
      bus_if.busy = 1'b0;
      #1;
      chk("drop_no_ack", 32'(bus_if.req_ack), 0);
      step();
      chk("drop_vld", 32'(bus_if.cmd_vld), 0);
      chk("drop_owed", 32'(refresh_owed), 0);
      chk("drop_err_sticky", 32'(refresh_err), 1);
      chk("drop_stat_refresh", 32'(stat_refresh), 0);
      ddr_ready = 1'b1;
      repeat (2) step();
      chk("drop_vld_after_ready", 32'(bus_if.cmd_vld), 0);
      chk("drop_owed_after_ready", 32'(refresh_owed), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
